clint: RTL and testbench

Core-local interrupt/exception sequencer. It detects ECALL, EBREAK, MRET and external interrupts, raises the clint stall request to the pipeline controller, and writes the trap CSRs one per cycle. It then issues a one-cycle redirect (assert + target address). It sits beside EX and is the requesting side of the pipeline controller's stall/flush interface: its stall output feeds the controller's clint stall input, which both stalls every stage and flushes the pipeline.

---
 rtl/clint.sv | 139 +++++++++++++
 tb/tb_clint.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clint.sv
// clint: core-local interrupt/exception sequencer.
// Detects ECALL/EBREAK/MRET/external interrupts in EX, stalls and flushes the
// pipeline, writes the trap CSRs one per cycle, then issues a one-cycle redirect.
module clint (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] inst_i,
   input  logic [31:0] inst_addr_i,
   input  logic        jump_assert_i,
   input  logic [31:0] jump_addr_i,
   input  logic [7:0]  int_flag_i,
   input  logic        global_int_en_i,
   input  logic [31:0] csr_mtvec_i,
   input  logic [31:0] csr_mepc_i,
   input  logic [31:0] csr_mstatus_i,
   output logic        stall_o,
   output logic        we_o,
   output logic [31:0] waddr_o,
   output logic [31:0] data_o,
   output logic        int_assert_o,
   output logic [31:0] int_addr_o
);

   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INST_MRET   = 32'h3020_0073;
   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;
   localparam logic [31:0] CAUSE_ECALL  = 32'd11;
   localparam logic [31:0] CAUSE_EBREAK = 32'd3;
   localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;

   typedef enum logic [2:0] {
      IDLE,
      W_MEPC,
      W_MCAUSE,
      W_MSTATUS,
      W_MSTATUS_MRET,
      ASSERT
   } state_t;

   state_t      r_state;
   logic [31:0] r_cause;
   logic [31:0] r_ms;
   logic [31:0] r_target;

   logic        w_ecall;
   logic        w_sync;
   logic        w_mret;
   logic        w_async;
   logic        w_event;
   logic [31:0] w_epc;
   logic [31:0] w_mret_ms;

   // Event decode; priority is sync > mret > async
   always_comb begin
      w_ecall   = (inst_i == INST_ECALL);
      w_sync    = w_ecall || (inst_i == INST_EBREAK);
      w_mret    = !w_sync && (inst_i == INST_MRET);
      w_async   = !w_sync && !w_mret && (|int_flag_i) && global_int_en_i;
      w_event   = w_sync || w_mret || w_async;
      w_epc     = (w_async && jump_assert_i) ? jump_addr_i : inst_addr_i;
      w_mret_ms = (csr_mstatus_i & ~32'h0000_0008)
                | {28'h0, csr_mstatus_i[7], 3'h0}
                | 32'h0000_0080;
   end

   // Stall is raised combinationally on the detection cycle and held until redirect
   assign stall_o = (r_state != IDLE) || w_event;

   // Sequencer: outputs are loaded on the transition into the state that shows them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_cause      <= 32'h0;
         r_ms         <= 32'h0;
         r_target     <= 32'h0;
         we_o         <= 1'b0;
         waddr_o      <= 32'h0;
         data_o       <= 32'h0;
         int_assert_o <= 1'b0;
         int_addr_o   <= 32'h0;
      end else begin
         case (r_state)
            IDLE: begin
               we_o         <= 1'b0;
               int_assert_o <= 1'b0;
               if (w_sync || w_async) begin
                  r_cause  <= w_async ? CAUSE_EXT : (w_ecall ? CAUSE_ECALL : CAUSE_EBREAK);
                  r_ms     <= csr_mstatus_i;
                  r_target <= csr_mtvec_i;
                  we_o     <= 1'b1;
                  waddr_o  <= {20'h0, CSR_MEPC};
                  data_o   <= w_epc;
                  r_state  <= W_MEPC;
               end else if (w_mret) begin
                  r_ms     <= csr_mstatus_i;
                  r_target <= csr_mepc_i;
                  we_o     <= 1'b1;
                  waddr_o  <= {20'h0, CSR_MSTATUS};
                  data_o   <= w_mret_ms;
                  r_state  <= W_MSTATUS_MRET;
               end
            end
            W_MEPC: begin
               we_o    <= 1'b1;
               waddr_o <= {20'h0, CSR_MCAUSE};
               data_o  <= r_cause;
               r_state <= W_MCAUSE;
            end
            W_MCAUSE: begin
               // MPIE <- MIE, MIE <- 0
               we_o    <= 1'b1;
               waddr_o <= {20'h0, CSR_MSTATUS};
               data_o  <= (r_ms & ~32'h0000_0088) | {24'h0, r_ms[3], 7'h0};
               r_state <= W_MSTATUS;
            end
            W_MSTATUS, W_MSTATUS_MRET: begin
               we_o         <= 1'b0;
               int_assert_o <= 1'b1;
               int_addr_o   <= r_target;
               r_state      <= ASSERT;
            end
            ASSERT: begin
               we_o         <= 1'b0;
               int_assert_o <= 1'b0;
               r_state      <= IDLE;
            end
            default: begin
               we_o         <= 1'b0;
               int_assert_o <= 1'b0;
               r_state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_clint.sv
// tb_clint: directed self-checking bench for the clint trap sequencer.
module tb_clint;

   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] MRET   = 32'h3020_0073;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] inst_i;
   logic [31:0] inst_addr_i;
   logic        jump_assert_i;
   logic [31:0] jump_addr_i;
   logic [7:0]  int_flag_i;
   logic        global_int_en_i;
   logic [31:0] csr_mtvec_i;
   logic [31:0] csr_mepc_i;
   logic [31:0] csr_mstatus_i;
   logic        stall_o;
   logic        we_o;
   logic [31:0] waddr_o;
   logic [31:0] data_o;
   logic        int_assert_o;
   logic [31:0] int_addr_o;

   int checks   = 0;
   int failures = 0;

   // Observed vector: {stall, we, waddr, data, int_assert, int_addr}
   logic [98:0] w_obs;
   logic [98:0] e;
   assign w_obs = {stall_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o};

   clint dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .inst_i          (inst_i),
      .inst_addr_i     (inst_addr_i),
      .jump_assert_i   (jump_assert_i),
      .jump_addr_i     (jump_addr_i),
      .int_flag_i      (int_flag_i),
      .global_int_en_i (global_int_en_i),
      .csr_mtvec_i     (csr_mtvec_i),
      .csr_mepc_i      (csr_mepc_i),
      .csr_mstatus_i   (csr_mstatus_i),
      .stall_o         (stall_o),
      .we_o            (we_o),
      .waddr_o         (waddr_o),
      .data_o          (data_o),
      .int_assert_o    (int_assert_o),
      .int_addr_o      (int_addr_o)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n = 1'b0;
      inst_i = NOP; inst_addr_i = 32'h0; jump_assert_i = 1'b0; jump_addr_i = 32'h0;
      int_flag_i = 8'h0; global_int_en_i = 1'b0; csr_mtvec_i = 32'h200;
      csr_mepc_i = 32'h0; csr_mstatus_i = 32'h0;
      #12;
      e = {1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL reset got=%h exp=%h", w_obs, e); end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      e = {1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL reset_idle got=%h exp=%h", w_obs, e); end
   endtask

   task automatic test_ecall();
      inst_i = ECALL; inst_addr_i = 32'h100; csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h200;
      #1;
      e = {1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL ecall_t0 got=%h exp=%h", w_obs, e); end
      @(negedge clk);
      e = {1'b1, 1'b1, 32'h341, 32'h100, 1'b0, 32'h0};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL ecall_t1 got=%h exp=%h", w_obs, e); end
      // Scramble inputs: sequence must use values latched at T
      inst_i = NOP; inst_addr_i = 32'h999; csr_mtvec_i = 32'h777; csr_mstatus_i = 32'hFF;
      @(negedge clk);
      e = {1'b1, 1'b1, 32'h342, 32'd11, 1'b0, 32'h0};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL ecall_t2 got=%h exp=%h", w_obs, e); end
      @(negedge clk);
      e = {1'b1, 1'b1, 32'h300, 32'h80, 1'b0, 32'h0};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL ecall_t3 got=%h exp=%h", w_obs, e); end
      @(negedge clk);
      e = {1'b1, 1'b0, 32'h300, 32'h80, 1'b1, 32'h200};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL ecall_t4 got=%h exp=%h", w_obs, e); end
      @(negedge clk);
      e = {1'b0, 1'b0, 32'h300, 32'h80, 1'b0, 32'h200};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL ecall_t5 got=%h exp=%h", w_obs, e); end
      csr_mtvec_i = 32'h200; csr_mstatus_i = 32'h0;
   endtask

   task automatic test_async_jump();
      int_flag_i = 8'h01; global_int_en_i = 1'b1; jump_assert_i = 1'b1; jump_addr_i = 32'h3C;
      inst_addr_i = 32'h50; csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h240;
      #1;
      e = {1'b1, 1'b0, 32'h300, 32'h80, 1'b0, 32'h200};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL async_t0 got=%h exp=%h", w_obs, e); end
      @(negedge clk);
      e = {1'b1, 1'b1, 32'h341, 32'h3C, 1'b0, 32'h200};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL async_t1 got=%h exp=%h", w_obs, e); end
      int_flag_i = 8'h0; global_int_en_i = 1'b0; jump_assert_i = 1'b0; csr_mtvec_i = 32'h200;
      @(negedge clk);
      e = {1'b1, 1'b1, 32'h342, 32'h8000000B, 1'b0, 32'h200};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL async_t2 got=%h exp=%h", w_obs, e); end
      @(negedge clk);
      e = {1'b1, 1'b1, 32'h300, 32'h80, 1'b0, 32'h200};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL async_t3 got=%h exp=%h", w_obs, e); end
      @(negedge clk);
      e = {1'b1, 1'b0, 32'h300, 32'h80, 1'b1, 32'h240};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL async_t4 got=%h exp=%h", w_obs, e); end
      @(negedge clk);
      e = {1'b0, 1'b0, 32'h300, 32'h80, 1'b0, 32'h240};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL async_t5 got=%h exp=%h", w_obs, e); end
   endtask

   task automatic test_mret();
      inst_i = MRET; csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104;
      #1;
      e = {1'b1, 1'b0, 32'h300, 32'h80, 1'b0, 32'h240};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL mret_t0 got=%h exp=%h", w_obs, e); end
      @(negedge clk);
      e = {1'b1, 1'b1, 32'h300, 32'h88, 1'b0, 32'h240};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL mret_t1 got=%h exp=%h", w_obs, e); end
      inst_i = NOP; csr_mepc_i = 32'h0; csr_mstatus_i = 32'h0;
      @(negedge clk);
      e = {1'b1, 1'b0, 32'h300, 32'h88, 1'b1, 32'h104};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL mret_t2 got=%h exp=%h", w_obs, e); end
      @(negedge clk);
      e = {1'b0, 1'b0, 32'h300, 32'h88, 1'b0, 32'h104};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL mret_t3 got=%h exp=%h", w_obs, e); end
   endtask

   task automatic test_masked_then_ebreak();
      int_flag_i = 8'hFF; global_int_en_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         e = {1'b0, 1'b0, 32'h300, 32'h88, 1'b0, 32'h104};
         checks++; if (w_obs !== e) begin failures++; $display("FAIL masked_c%0d got=%h exp=%h", i, w_obs, e); end
         @(negedge clk);
      end
      inst_i = EBREAK; inst_addr_i = 32'h40; csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h200;
      #1;
      e = {1'b1, 1'b0, 32'h300, 32'h88, 1'b0, 32'h104};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL ebreak_t0 got=%h exp=%h", w_obs, e); end
      @(negedge clk);
      e = {1'b1, 1'b1, 32'h341, 32'h40, 1'b0, 32'h104};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL ebreak_t1 got=%h exp=%h", w_obs, e); end
      inst_i = NOP;
      @(negedge clk);
      e = {1'b1, 1'b1, 32'h342, 32'd3, 1'b0, 32'h104};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL ebreak_t2 got=%h exp=%h", w_obs, e); end
      @(negedge clk);
      e = {1'b1, 1'b1, 32'h300, 32'h80, 1'b0, 32'h104};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL ebreak_t3 got=%h exp=%h", w_obs, e); end
      @(negedge clk);
      e = {1'b1, 1'b0, 32'h300, 32'h80, 1'b1, 32'h200};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL ebreak_t4 got=%h exp=%h", w_obs, e); end
      @(negedge clk);
      e = {1'b0, 1'b0, 32'h300, 32'h80, 1'b0, 32'h200};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL ebreak_t5 got=%h exp=%h", w_obs, e); end
      int_flag_i = 8'h0;
   endtask

   task automatic test_sync_priority();
      inst_i = EBREAK; inst_addr_i = 32'h60; int_flag_i = 8'h01; global_int_en_i = 1'b1;
      jump_assert_i = 1'b1; jump_addr_i = 32'h3C; csr_mstatus_i = 32'h8;
      #1;
      e = {1'b1, 1'b0, 32'h300, 32'h80, 1'b0, 32'h200};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL prio_t0 got=%h exp=%h", w_obs, e); end
      @(negedge clk);
      e = {1'b1, 1'b1, 32'h341, 32'h60, 1'b0, 32'h200};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL prio_t1 got=%h exp=%h", w_obs, e); end
      // Interrupt stays pending but the written mstatus has MIE cleared
      inst_i = NOP; jump_assert_i = 1'b0; global_int_en_i = 1'b0; csr_mstatus_i = 32'h80;
      @(negedge clk);
      e = {1'b1, 1'b1, 32'h342, 32'd3, 1'b0, 32'h200};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL prio_t2 got=%h exp=%h", w_obs, e); end
      @(negedge clk);
      e = {1'b1, 1'b1, 32'h300, 32'h80, 1'b0, 32'h200};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL prio_t3 got=%h exp=%h", w_obs, e); end
      @(negedge clk);
      e = {1'b1, 1'b0, 32'h300, 32'h80, 1'b1, 32'h200};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL prio_t4 got=%h exp=%h", w_obs, e); end
      for (int i = 5; i < 8; i++) begin
         @(negedge clk);
         e = {1'b0, 1'b0, 32'h300, 32'h80, 1'b0, 32'h200};
         checks++; if (w_obs !== e) begin failures++; $display("FAIL prio_t%0d got=%h exp=%h", i, w_obs, e); end
      end
      int_flag_i = 8'h0; csr_mstatus_i = 32'h0;
   endtask

   task automatic test_reset_mid();
      inst_i = ECALL; inst_addr_i = 32'h100; csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h300;
      @(negedge clk);
      e = {1'b1, 1'b1, 32'h341, 32'h100, 1'b0, 32'h200};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL rstmid_t1 got=%h exp=%h", w_obs, e); end
      inst_i = NOP;
      @(negedge clk);
      e = {1'b1, 1'b1, 32'h342, 32'd11, 1'b0, 32'h200};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL rstmid_t2 got=%h exp=%h", w_obs, e); end
      #2 rst_n = 1'b0;
      #1;
      e = {1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL rstmid_async got=%h exp=%h", w_obs, e); end
      @(negedge clk); rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         e = {1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0};
         checks++; if (w_obs !== e) begin failures++; $display("FAIL rstmid_quiet%0d got=%h exp=%h", i, w_obs, e); end
      end
   endtask

   task automatic test_back_to_back();
      inst_i = ECALL; inst_addr_i = 32'h120; csr_mstatus_i = 32'h0; csr_mtvec_i = 32'h300;
      #1;
      e = {1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL fresh_t0 got=%h exp=%h", w_obs, e); end
      @(negedge clk);
      e = {1'b1, 1'b1, 32'h341, 32'h120, 1'b0, 32'h0};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL fresh_t1 got=%h exp=%h", w_obs, e); end
      inst_i = NOP;
      @(negedge clk);
      e = {1'b1, 1'b1, 32'h342, 32'd11, 1'b0, 32'h0};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL fresh_t2 got=%h exp=%h", w_obs, e); end
      @(negedge clk);
      e = {1'b1, 1'b1, 32'h300, 32'h0, 1'b0, 32'h0};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL fresh_t3 got=%h exp=%h", w_obs, e); end
      @(negedge clk);
      e = {1'b1, 1'b0, 32'h300, 32'h0, 1'b1, 32'h300};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL fresh_t4 got=%h exp=%h", w_obs, e); end
      @(negedge clk);
      e = {1'b0, 1'b0, 32'h300, 32'h0, 1'b0, 32'h300};
      checks++; if (w_obs !== e) begin failures++; $display("FAIL fresh_t5 got=%h exp=%h", w_obs, e); end
   endtask

   initial begin
      test_reset();
      test_ecall();
      test_async_jump();
      test_mret();
      test_masked_then_ebreak();
      test_sync_priority();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
